// File: rtl/pipe_ctrl_chain.sv
// pipe_ctrl_chain: valid/data register chain with stall, bubble and partial flush.
// Optional saturating stall/flush counters when PIPE_CTRL_PERF_EN is defined.
module pipe_ctrl_chain #(
    parameter int DATA_W = 32,
    parameter int STAGES = 4,
    parameter int CNT_W  = 16
) (
    input  logic                        clk,
    input  logic                        srst,
    input  logic                        enable,
    input  logic                        in_valid,
    input  logic [DATA_W-1:0]           in_data,
    output logic                        in_ready,
    input  logic [STAGES-1:0]           stall_req,
    input  logic                        flush_req,
    input  logic [$clog2(STAGES)-1:0]   flush_stage,
    output logic [STAGES-1:0]           stage_valid,
    output logic [STAGES*DATA_W-1:0]    stage_data,
    output logic                        out_valid,
    output logic [DATA_W-1:0]           out_data,
    output logic [CNT_W-1:0]            stall_cnt,
    output logic [CNT_W-1:0]            flush_cnt
);
    localparam int FW = $clog2(STAGES);
    logic [STAGES-1:0]        hold, valid_q, valid_d;
    logic [STAGES*DATA_W-1:0] data_q, data_d;
    logic                     flush, bubble;
    logic [FW-1:0]            f;
    assign flush    = enable && flush_req;
    assign f        = (flush_stage > FW'(STAGES-1)) ? FW'(STAGES-1) : flush_stage;
    assign in_ready = !hold[0] && !flush;
    // A stall at stage k holds every older-to-younger slot 0..k.
    always_comb begin
        hold[STAGES-1] = !enable || stall_req[STAGES-1];
        for (int i = STAGES-2; i >= 0; i--) hold[i] = hold[i+1] || stall_req[i];
    end
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        bubble  = 1'b0;
        if (!hold[0]) begin
            valid_d[0]          = in_valid;
            data_d[DATA_W-1:0]  = in_data;
        end
        for (int i = 1; i < STAGES; i++) begin
            if (!hold[i]) begin
                // The slot just above a flush point takes the surviving instruction, not a bubble.
                bubble = hold[i-1] && !(flush && (i-1) == int'(f));
                valid_d[i]                 = bubble ? 1'b0 : valid_q[i-1];
                data_d[i*DATA_W +: DATA_W] = bubble ? '0 : data_q[(i-1)*DATA_W +: DATA_W];
            end
        end
        for (int i = 0; i < STAGES; i++) begin
            if (flush && i <= int'(f)) begin
                valid_d[i]                 = 1'b0;
                data_d[i*DATA_W +: DATA_W] = '0;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (srst) begin
            valid_q <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end
    assign stage_valid = valid_q;
    assign stage_data  = data_q;
    assign out_valid   = valid_q[STAGES-1];
    assign out_data    = data_q[(STAGES-1)*DATA_W +: DATA_W];
`ifdef PIPE_CTRL_PERF_EN
    logic [CNT_W-1:0] sc_q, fc_q;
    always_ff @(posedge clk) begin
        if (srst) begin
            sc_q <= '0;
            fc_q <= '0;
        end else begin
            if (enable && |stall_req && !(&sc_q)) sc_q <= sc_q + 1'b1;
            if (flush && !(&fc_q)) fc_q <= fc_q + 1'b1;
        end
    end
    assign stall_cnt = sc_q;
    assign flush_cnt = fc_q;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif
endmodule

// File: tb/tb_pipe_ctrl_chain.sv
// tb_pipe_ctrl_chain: table-driven directed check of pipe_ctrl_chain (STAGES=4, DATA_W=8, CNT_W=2).
module tb_pipe_ctrl_chain;
`ifdef PIPE_CTRL_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif
    logic        clk = 1'b0;
    logic        srst, enable, in_valid, in_ready, flush_req, out_valid;
    logic [7:0]  in_data, out_data;
    logic [3:0]  stall_req, stage_valid;
    logic [1:0]  flush_stage, stall_cnt, flush_cnt;
    logic [31:0] stage_data;
    int          n_chk = 0, n_fail = 0;

    typedef struct {
        logic en, rst; logic [3:0] st; logic fl; logic [1:0] fs; logic iv; logic [7:0] id;
        logic rdy; logic [3:0] v; logic [31:0] d; logic [1:0] sc, fc;
    } vec_t;
    vec_t vq[$];

    pipe_ctrl_chain #(.DATA_W(8), .STAGES(4), .CNT_W(2)) dut (
        .clk(clk), .srst(srst), .enable(enable), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .stall_req(stall_req), .flush_req(flush_req),
        .flush_stage(flush_stage), .stage_valid(stage_valid), .stage_data(stage_data),
        .out_valid(out_valid), .out_data(out_data), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic add(input logic en, rst, input logic [3:0] st, input logic fl, input logic [1:0] fs,
                       input logic iv, input logic [7:0] id, input logic rdy, input logic [3:0] v,
                       input logic [31:0] d, input logic [1:0] sc, fc);
        vq.push_back('{en, rst, st, fl, fs, iv, id, rdy, v, d, sc, fc});
    endtask

    task automatic idle(input logic [3:0] v, input logic [31:0] d, input logic [1:0] sc, fc);
        add(1, 0, 0, 0, 0, 0, 0, 1, v, d, sc, fc);
    endtask

    task automatic fill(input logic [1:0] sc, fc);
        add(1, 0, 0, 0, 0, 1, 8'h11, 1, 4'b0001, 32'h00000011, sc, fc);
        add(1, 0, 0, 0, 0, 1, 8'h22, 1, 4'b0011, 32'h00001122, sc, fc);
        add(1, 0, 0, 0, 0, 1, 8'h33, 1, 4'b0111, 32'h00112233, sc, fc);
        add(1, 0, 0, 0, 0, 1, 8'h44, 1, 4'b1111, 32'h11223344, sc, fc);
    endtask

    initial begin
        int edges;
        bit seen;
        logic [1:0] sat [6] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3};
        srst = 1; enable = 1; in_valid = 0; in_data = 0; stall_req = 0; flush_req = 0; flush_stage = 0;
        // reset, then streaming of three payloads
        add(1, 1, 0, 0, 0, 0, 0, 1, 4'b0000, 32'h0, 0, 0);
        add(1, 0, 0, 0, 0, 1, 8'h11, 1, 4'b0001, 32'h00000011, 0, 0);
        add(1, 0, 0, 0, 0, 1, 8'h22, 1, 4'b0011, 32'h00001122, 0, 0);
        add(1, 0, 0, 0, 0, 1, 8'h33, 1, 4'b0111, 32'h00112233, 0, 0);
        idle(4'b1110, 32'h11223300, 0, 0);
        idle(4'b1100, 32'h22330000, 0, 0);
        idle(4'b1000, 32'h33000000, 0, 0);
        idle(4'b0000, 32'h0, 0, 0);
        // stall at stage 1 for two cycles: two bubbles into slot 2
        fill(0, 0);
        add(1, 0, 4'b0010, 0, 0, 1, 8'h55, 0, 4'b1011, 32'h22003344, 1, 0);
        add(1, 0, 4'b0010, 0, 0, 1, 8'h55, 0, 4'b0011, 32'h00003344, 2, 0);
        add(1, 0, 4'b0000, 0, 0, 1, 8'h55, 1, 4'b0111, 32'h00334455, 2, 0);
        idle(4'b1110, 32'h33445500, 2, 0);
        idle(4'b1100, 32'h44550000, 2, 0);
        idle(4'b1000, 32'h55000000, 2, 0);
        idle(4'b0000, 32'h0, 2, 0);
        // flush at stage 2
        fill(2, 0);
        add(1, 0, 0, 1, 2, 1, 8'h66, 0, 4'b1000, 32'h22000000, 2, 1);
        idle(4'b0000, 32'h0, 2, 1);
        // flush at stage 1 together with a stall at stage 1
        fill(2, 1);
        add(1, 0, 4'b0010, 1, 1, 0, 0, 0, 4'b1100, 32'h22330000, 3, 2);
        idle(4'b1000, 32'h33000000, 3, 2);
        idle(4'b0000, 32'h0, 3, 2);
        // enable low freezes everything, then reset clears a full pipe
        fill(3, 2);
        for (int i = 0; i < 3; i++) add(0, 0, 4'b1111, 1, 0, 1, 8'h77, 0, 4'b1111, 32'h11223344, 3, 2);
        add(1, 1, 0, 0, 0, 0, 0, 1, 4'b0000, 32'h0, 0, 0);
        // counter saturation with a last-stage stall
        for (int i = 0; i < 6; i++) add(1, 0, 4'b1000, 0, 0, 0, 0, 0, 4'b0000, 32'h0, sat[i], 0);
        // flush at the last stage clears all; flush at stage 0 kills only slot 0
        fill(3, 0);
        add(1, 0, 0, 1, 3, 0, 0, 0, 4'b0000, 32'h0, 3, 1);
        fill(3, 1);
        add(1, 0, 0, 1, 0, 0, 0, 0, 4'b1110, 32'h22334400, 3, 2);
        idle(4'b1100, 32'h33440000, 3, 2);

        foreach (vq[k]) begin
            @(negedge clk);
            enable = vq[k].en; srst = vq[k].rst; stall_req = vq[k].st; flush_req = vq[k].fl;
            flush_stage = vq[k].fs; in_valid = vq[k].iv; in_data = vq[k].id;
            #1 chk("in_ready", k, 32'(in_ready), 32'(vq[k].rdy));
            @(posedge clk); #1;
            chk("stage_valid", k, 32'(stage_valid), 32'(vq[k].v));
            chk("stage_data", k, stage_data, vq[k].d);
            chk("out_valid", k, 32'(out_valid), 32'(vq[k].v[3]));
            chk("out_data", k, 32'(out_data), 32'(vq[k].d[31:24]));
            chk("stall_cnt", k, 32'(stall_cnt), PERF ? 32'(vq[k].sc) : 32'h0);
            chk("flush_cnt", k, 32'(flush_cnt), PERF ? 32'(vq[k].fc) : 32'h0);
        end

        // in_ready must not depend on in_valid
        @(negedge clk);
        srst = 0; enable = 1; flush_req = 0; stall_req = 0; in_valid = 0;
        #1 chk("ready_iv0", 0, 32'(in_ready), 32'h1);
        in_valid = 1;
        #1 chk("ready_iv1", 0, 32'(in_ready), 32'h1);
        stall_req = 4'b1000;
        #1 chk("ready_stall_iv1", 0, 32'(in_ready), 32'h0);
        in_valid = 0;
        #1 chk("ready_stall_iv0", 0, 32'(in_ready), 32'h0);

        // first accepted instruction after reset reaches out_valid four edges later
        stall_req = 0; srst = 1;
        @(posedge clk);
        @(negedge clk);
        srst = 0; in_valid = 1; in_data = 8'hA5;
        edges = 0; seen = 0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(posedge clk); #1;
            edges++;
            in_valid = 0; in_data = 0;
            seen = out_valid;
        end
        chk("latency", 0, 32'(edges), 32'd4);
        chk("latency_data", 0, 32'(out_data), 32'hA5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
